// File: rtl/control_loop_cmd_queue_pkg.sv
// rtl/control_loop_cmd_queue_pkg.sv - command codes and queue FSM encodings for the control loop
// Purpose: shared command-code constants, the write-bit position and the
//          2-bit request-queue FSM state type.
// Ports:   none (package).
package control_loop_cmd_queue_pkg;

  localparam int CONTROL_LOOP_CMD_WIDTH = 8;
  localparam int CONTROL_LOOP_WRITE_BIT = 7;

  localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CMD_STATUS = 8'h01;
  localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CMD_SETPT  = 8'h02;
  localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CMD_CYCLES = 8'h03;
  localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CMD_GAIN   = 8'h04;

  typedef enum logic [1:0] {
    CONTROL_LOOP_CMD_Q_IDLE    = 2'd0,
    CONTROL_LOOP_CMD_Q_ISSUE   = 2'd1,
    CONTROL_LOOP_CMD_Q_RELEASE = 2'd2
  } cmd_q_state_e;

  function automatic logic [CONTROL_LOOP_CMD_WIDTH-1:0] cmd_with_write(
      input logic [CONTROL_LOOP_CMD_WIDTH-1:0] code);
    logic [CONTROL_LOOP_CMD_WIDTH-1:0] r;
    r = code;
    r[CONTROL_LOOP_WRITE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/control_loop_cmd_queue_sync_fifo.sv
// rtl/control_loop_cmd_queue_sync_fifo.sv - synchronous request FIFO without fall-through
// Purpose: DEPTH-entry storage for queued requests. rdata always shows the
//          entry at the read pointer; the consumer latches it when it pops.
//          full is registered from the next-state count.
// Ports:   clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty.
module control_loop_cmd_queue_sync_fifo #(
  parameter int WID   = 72,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [WID-1:0] wdata,
  input  logic           pop,
  output logic [WID-1:0] rdata,
  output logic           full,
  output logic           empty
);

  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WID-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           full_q, full_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/control_loop_cmd_queue.sv
// rtl/control_loop_cmd_queue.sv - CPU request queue driving the control loop cmd handshake
// Purpose: queues CPU requests, issues them one at a time on the loop's
//          cmd/word_in/start_cmd/finish_cmd handshake, returns word_out as a
//          held response and aborts commands that never finish via a timer.
// Ports:   clk, rst (sync, active-high)
//          req_valid/req_ready/req_cmd/req_word       CPU request
//          rsp_valid/rsp_ready/rsp_word/rsp_timeout   CPU response
//          cl_cmd/cl_word_in/cl_start                 to loop
//          cl_word_out/cl_finish                      from loop
//          stat_done/stat_timeout  only when CONTROL_LOOP_CMD_STATS_EN is defined
module control_loop_cmd_queue
  import control_loop_cmd_queue_pkg::*;
#(
  parameter int CMD_WID     = CONTROL_LOOP_CMD_WIDTH,
  parameter int DATA_WID    = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT     = 1048575,
  parameter int TIMEOUT_WID = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CMD_WID-1:0]  req_cmd,
  input  logic [DATA_WID-1:0] req_word,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_WID-1:0] rsp_word,
  output logic                rsp_timeout,
  output logic [CMD_WID-1:0]  cl_cmd,
  output logic [DATA_WID-1:0] cl_word_in,
  input  logic [DATA_WID-1:0] cl_word_out,
  output logic                cl_start,
  input  logic                cl_finish
`ifdef CONTROL_LOOP_CMD_STATS_EN
  ,
  output logic [31:0]         stat_done,
  output logic [15:0]         stat_timeout
`endif
);

  localparam int ENTRY_WID = CMD_WID + DATA_WID;
  localparam logic [TIMEOUT_WID-1:0] TIMER_LAST = TIMEOUT_WID'(TIMEOUT - 1);

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_WID-1:0] fifo_head;

  cmd_q_state_e         state_q, state_d;
  logic [TIMEOUT_WID-1:0] timer_q, timer_d;
  logic [CMD_WID-1:0]   cl_cmd_q, cl_cmd_d;
  logic [DATA_WID-1:0]  cl_word_in_q, cl_word_in_d;
  logic                 cl_start_q, cl_start_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_WID-1:0]  rsp_word_q, rsp_word_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 rsp_set;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;

  control_loop_cmd_queue_sync_fifo #(
    .WID   (ENTRY_WID),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({req_cmd, req_word}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cl_cmd_d      = cl_cmd_q;
    cl_word_in_d  = cl_word_in_q;
    cl_start_d    = cl_start_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_word_d    = rsp_word_q;
    rsp_timeout_d = rsp_timeout_q;
    fifo_pop      = 1'b0;
    rsp_set       = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      CONTROL_LOOP_CMD_Q_IDLE: begin
        // Waiting for the previous response to be consumed keeps exactly one
        // command in flight; a finish still high from the loop must drop first.
        if (!fifo_empty && !rsp_valid_q && !cl_finish) begin
          cl_cmd_d     = fifo_head[ENTRY_WID-1:DATA_WID];
          cl_word_in_d = fifo_head[DATA_WID-1:0];
          fifo_pop     = 1'b1;
          timer_d      = '0;
          state_d      = CONTROL_LOOP_CMD_Q_ISSUE;
        end
      end
      CONTROL_LOOP_CMD_Q_ISSUE: begin
        // cl_start is registered, so it rises one cycle after cmd/word settle.
        cl_start_d = 1'b1;
        timer_d    = timer_q + TIMEOUT_WID'(1);
        if (cl_finish) begin
          rsp_word_d    = cl_word_out;
          rsp_timeout_d = 1'b0;
          cl_start_d    = 1'b0;
          state_d       = CONTROL_LOOP_CMD_Q_RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          rsp_word_d    = '0;
          rsp_timeout_d = 1'b1;
          cl_start_d    = 1'b0;
          state_d       = CONTROL_LOOP_CMD_Q_RELEASE;
        end
      end
      CONTROL_LOOP_CMD_Q_RELEASE: begin
        if (!cl_finish) begin
          rsp_valid_d = 1'b1;
          rsp_set     = 1'b1;
          state_d     = CONTROL_LOOP_CMD_Q_IDLE;
        end
      end
      default: begin
        cl_start_d = 1'b0;
        state_d    = CONTROL_LOOP_CMD_Q_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CONTROL_LOOP_CMD_Q_IDLE;
      timer_q       <= '0;
      cl_cmd_q      <= '0;
      cl_word_in_q  <= '0;
      cl_start_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_word_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cl_cmd_q      <= cl_cmd_d;
      cl_word_in_q  <= cl_word_in_d;
      cl_start_q    <= cl_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_word_q    <= rsp_word_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cl_cmd      = cl_cmd_q;
  assign cl_word_in  = cl_word_in_q;
  assign cl_start    = cl_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_word    = rsp_word_q;
  assign rsp_timeout = rsp_timeout_q;

`ifdef CONTROL_LOOP_CMD_STATS_EN
  logic [31:0] stat_done_q, stat_done_d;
  logic [15:0] stat_timeout_q, stat_timeout_d;

  // rsp_timeout_q already holds the outcome when the response is raised.
  always_comb begin
    stat_done_d    = stat_done_q;
    stat_timeout_d = stat_timeout_q;
    if (rsp_set && !rsp_timeout_q && (stat_done_q != '1)) begin
      stat_done_d = stat_done_q + 32'd1;
    end
    if (rsp_set && rsp_timeout_q && (stat_timeout_q != '1)) begin
      stat_timeout_d = stat_timeout_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done_q    <= '0;
      stat_timeout_q <= '0;
    end else begin
      stat_done_q    <= stat_done_d;
      stat_timeout_q <= stat_timeout_d;
    end
  end

  assign stat_done    = stat_done_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule

// File: tb/tb_control_loop_cmd_queue.sv
// tb/tb_control_loop_cmd_queue.sv - self-checking bench for control_loop_cmd_queue
module tb_control_loop_cmd_queue;
  import control_loop_cmd_queue_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = '0;
  logic [63:0] req_word = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_word;
  logic        rsp_timeout;
  logic [7:0]  cl_cmd;
  logic [63:0] cl_word_in;
  logic [63:0] cl_word_out = '0;
  logic        cl_start;
  logic        cl_finish = 1'b0;
`ifdef CONTROL_LOOP_CMD_STATS_EN
  logic [31:0] stat_done;
  logic [15:0] stat_timeout;
`endif

  control_loop_cmd_queue #(
    .TIMEOUT     (TMO),
    .TIMEOUT_WID (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_word    (req_word),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_word    (rsp_word),
    .rsp_timeout (rsp_timeout),
    .cl_cmd      (cl_cmd),
    .cl_word_in  (cl_word_in),
    .cl_word_out (cl_word_out),
    .cl_start    (cl_start),
    .cl_finish   (cl_finish)
`ifdef CONTROL_LOOP_CMD_STATS_EN
    ,
    .stat_done   (stat_done),
    .stat_timeout(stat_timeout)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] word;
    logic        to;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural loop: finishes known commands after loop_delay start cycles.
  int          loop_delay = 3;
  bit          loop_dead  = 1'b0;
  bit          loop_fixed = 1'b0;
  logic [63:0] loop_fixed_word = 64'd1;
  int          loop_cnt = 0;
  int          start_hi_cnt = 0;

  function automatic bit known(input logic [7:0] cmd);
    logic [6:0] c;
    c = cmd[6:0];
    return (c >= 7'd1) && (c <= 7'd4);
  endfunction

  function automatic logic [63:0] resp_fn(input logic [7:0] cmd, input logic [63:0] w);
    return w ^ {cmd, 56'h0} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      cl_finish = 1'b0;
      loop_cnt  = 0;
    end else if (cl_start) begin
      start_hi_cnt = start_hi_cnt + 1;
      if (!cl_finish) begin
        loop_cnt = loop_cnt + 1;
        if (!loop_dead && known(cl_cmd) && loop_cnt >= loop_delay) begin
          cl_finish   = 1'b1;
          cl_word_out = loop_fixed ? loop_fixed_word : resp_fn(cl_cmd, cl_word_in);
        end
      end
    end else begin
      loop_cnt  = 0;
      cl_finish = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tasks start and end just after a falling edge.
  task automatic send(input logic [7:0] cmd, input logic [63:0] word);
    int   n;
    exp_t e;
    req_cmd   = cmd;
    req_word  = word;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept_in_time", 64'(n < 300), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    e.to   = loop_dead || !known(cmd);
    e.word = e.to ? 64'd0 : (loop_fixed ? loop_fixed_word : resp_fn(cmd, word));
    exp_q.push_back(e);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
  endtask

  task automatic recv(input string tag);
    exp_t e;
    wait_rsp(tag);
    chk({tag, "_model_has_entry"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rsp_word"}, rsp_word, e.word);
      chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(e.to));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_cleared"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int   hold_starts;
    int   n;
    logic [7:0] rc;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_word", rsp_word, 64'd0);
    chk("reset_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("reset_cl_start", 64'(cl_start), 64'd0);
    chk("reset_cl_cmd", 64'(cl_cmd), 64'd0);
    chk("reset_cl_word_in", cl_word_in, 64'd0);

    // STATUS read, loop finishes after 3 start cycles with word_out=1.
    loop_fixed = 1'b1;
    loop_fixed_word = 64'd1;
    loop_delay = 3;
    start_hi_cnt = 0;
    send(CMD_STATUS, 64'd0);
    wait_rsp("status");
    chk("status_start_cycles", 64'(start_hi_cnt), 64'd3);
    chk("status_start_low", 64'(cl_start), 64'd0);

    // Response left pending: queue fills to 4, 5th waits for the first pop.
    loop_fixed = 1'b0;
    loop_delay = 2;
    for (int i = 0; i < 4; i++) begin
      send(cmd_with_write(CMD_SETPT), {$urandom, $urandom});
      if (i == 2) chk("ready_after_3", 64'(req_ready), 64'd1);
    end
    chk("full_after_4", 64'(req_ready), 64'd0);
    recv("status");
    chk("fifth_waits_for_pop", 64'(req_ready), 64'd0);
    send(cmd_with_write(CMD_SETPT), {$urandom, $urandom});
    for (int i = 0; i < 5; i++) recv("burst");

    // CYCLES read the loop never finishes.
    loop_dead = 1'b1;
    start_hi_cnt = 0;
    send(CMD_CYCLES, 64'd0);
    wait_rsp("timeout");
    chk("timeout_start_cycles", 64'(start_hi_cnt), 64'(TMO - 1));
    recv("timeout");
    loop_dead = 1'b0;

    // Unconsumed response blocks the second queued request.
    loop_delay = 2;
    send(CMD_GAIN, {$urandom, $urandom});
    send(cmd_with_write(CMD_GAIN), {$urandom, $urandom});
    wait_rsp("hold");
    hold_starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (cl_start) hold_starts++;
    end
    chk("hold_no_issue", 64'(hold_starts), 64'd0);
    recv("hold_first");
    recv("hold_second");

    // Randomized traffic including unknown codes.
    for (int i = 0; i < 10; i++) begin
      loop_delay = int'($urandom_range(1, 5));
      n = int'($urandom_range(0, 4));
      rc = (n == 0) ? 8'h1F : 8'(n);
      if ($urandom_range(0, 1) == 1) rc = cmd_with_write(rc);
      send(rc, {$urandom, $urandom});
      recv("random");
    end

    // Reset in ISSUE with one more request queued.
    loop_dead = 1'b1;
    send(CMD_STATUS, 64'd0);
    send(CMD_SETPT, 64'd5);
    n = 0;
    while (!cl_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_issue", 64'(cl_start), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cl_start", 64'(cl_start), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    loop_dead = 1'b0;
    hold_starts = 0;
    repeat (6) begin
      @(negedge clk);
      if (cl_start || rsp_valid) hold_starts++;
    end
    chk("rst_queue_empty", 64'(hold_starts), 64'd0);

`ifdef CONTROL_LOOP_CMD_STATS_EN
    loop_delay = 2;
    for (int i = 0; i < 3; i++) begin
      send(CMD_STATUS, 64'(i));
      recv("stats_good");
    end
    send(8'h1F, 64'd0);
    recv("stats_timeout");
    chk("stat_done", 64'(stat_done), 64'd3);
    chk("stat_timeout", 64'(stat_timeout), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
